// File: rtl/conv_layers.sv
// conv_layers: per-channel dot-product accumulate, bias, max-pool,
// ReLU and fixed-point rescale with a single-entry output register.
module conv_layers #(
  parameter int DEPTH_NB   = 1,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int KER_WIDTH  = 16,
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter logic [CFG_AWIDTH-1:0] CFG_LAYERS = CFG_AWIDTH'(2)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CFG_DWIDTH-1:0]                  cfg_data,
  input  logic [CFG_AWIDTH-1:0]                  cfg_addr,
  input  logic                                   cfg_valid,
  input  logic [DEPTH_NB*GROUP_NB*KER_WIDTH-1:0] bias_bus,
  input  logic [DEPTH_NB*GROUP_NB*KER_WIDTH-1:0] kernel_bus,
  output logic                                   kernel_rdy,
  input  logic [GROUP_NB*IMG_WIDTH-1:0]          image_bus,
  input  logic                                   image_last,
  input  logic                                   image_val,
  output logic                                   image_rdy,
  output logic [DEPTH_NB*IMG_WIDTH-1:0]          result_bus,
  output logic                                   result_val,
  input  logic                                   result_rdy
);

  localparam int ACC_W = GROUP_NB * KER_WIDTH;
  localparam int PW    = IMG_WIDTH + KER_WIDTH;

  typedef enum logic { UP_ACC, UP_DRAIN } up_t;
  typedef enum logic { DN_EMPTY, DN_FULL } dn_t;

  up_t up_state;
  dn_t dn_state;

  logic [1:0] bypass;
  logic [7:0] pool_nb;
  logic [7:0] shift;
  logic [7:0] head;
  logic [7:0] eff;
  logic       cfg_unused;

  logic accept;
  logic take;
  logic load;

  logic                    p_val;
  logic                    p_last;
  logic                    a_done;
  logic                    pool_rdy;
  logic [7:0]              pcnt;
  logic signed [ACC_W-1:0] psum   [DEPTH_NB];
  logic signed [ACC_W-1:0] acc    [DEPTH_NB];
  logic signed [ACC_W-1:0] biased [DEPTH_NB];
  logic signed [ACC_W-1:0] pmax   [DEPTH_NB];
  logic [DEPTH_NB*IMG_WIDTH-1:0] res_c;

  function automatic logic signed [ACC_W-1:0] dot(
    input logic [GROUP_NB*IMG_WIDTH-1:0] im,
    input logic [GROUP_NB*KER_WIDTH-1:0] ke
  );
    logic signed [ACC_W-1:0] s;
    logic signed [PW-1:0]    p;
    s = '0;
    for (int g = 0; g < GROUP_NB; g++) begin
      p = PW'($signed(im[g*IMG_WIDTH +: IMG_WIDTH]))
        * PW'($signed(ke[g*KER_WIDTH +: KER_WIDTH]));
      s = s + ACC_W'(p);
    end
    return s;
  endfunction

  function automatic logic [IMG_WIDTH-1:0] rescale(
    input logic signed [ACC_W-1:0] v,
    input logic [7:0]              sh,
    input logic [7:0]              hd
  );
    logic signed [ACC_W:0]   ve;
    logic signed [ACC_W:0]   lim;
    logic signed [ACC_W-1:0] s;
    logic                    can_sat;
    ve      = {v[ACC_W-1], v};
    lim     = (ACC_W+1)'(1) << hd;
    s       = v >>> sh;
    can_sat = hd < 8'(ACC_W);
    if (can_sat && ve >= lim)
      return {1'b0, {(IMG_WIDTH-1){1'b1}}};
    else if (can_sat && ve < -lim)
      return {1'b1, {(IMG_WIDTH-1){1'b0}}};
    else
      return s[IMG_WIDTH-1:0];
  endfunction

  assign cfg_unused = ^cfg_data[31:26];
  assign eff        = (bypass[1] || pool_nb == 8'd0) ? 8'd1 : pool_nb;
  assign accept     = image_val & image_rdy;
  assign kernel_rdy = accept;
  assign take       = a_done & ~pool_rdy;
  assign load       = pool_rdy & (dn_state == DN_EMPTY);
  assign result_val = (dn_state == DN_FULL);

  always_comb begin
    res_c = '0;
    for (int d = 0; d < DEPTH_NB; d++) begin
      biased[d] = acc[d] + $signed(bias_bus[d*ACC_W +: ACC_W]);
      res_c[d*IMG_WIDTH +: IMG_WIDTH] = rescale(
        (!bypass[0] && pmax[d][ACC_W-1]) ? '0 : pmax[d], shift, head);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bypass  <= '0;
      pool_nb <= 8'd1;
      shift   <= '0;
      head    <= 8'(IMG_WIDTH-1);
    end else if (cfg_valid && cfg_addr == CFG_LAYERS) begin
      bypass  <= cfg_data[25:24];
      pool_nb <= cfg_data[23:16];
      shift   <= cfg_data[15:8];
      head    <= cfg_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      up_state  <= UP_ACC;
      image_rdy <= 1'b0;
    end else begin
      unique case (up_state)
        UP_ACC: begin
          if (accept && image_last) begin
            up_state  <= UP_DRAIN;
            image_rdy <= 1'b0;
          end else begin
            image_rdy <= 1'b1;
          end
        end
        UP_DRAIN: begin
          if (take) begin
            up_state  <= UP_ACC;
            image_rdy <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_val  <= 1'b0;
      p_last <= 1'b0;
      a_done <= 1'b0;
      for (int d = 0; d < DEPTH_NB; d++) begin
        psum[d] <= '0;
        acc[d]  <= '0;
      end
    end else begin
      p_val  <= accept;
      p_last <= accept & image_last;
      if (accept)
        for (int d = 0; d < DEPTH_NB; d++)
          psum[d] <= dot(image_bus,
            kernel_bus[d*ACC_W +: ACC_W]);
      if (p_val)
        for (int d = 0; d < DEPTH_NB; d++)
          acc[d] <= acc[d] + psum[d];
      if (p_val && p_last)
        a_done <= 1'b1;
      // a new beat cannot arrive until take, so clearing here is safe
      if (take) begin
        a_done <= 1'b0;
        for (int d = 0; d < DEPTH_NB; d++)
          acc[d] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt     <= '0;
      pool_rdy <= 1'b0;
      for (int d = 0; d < DEPTH_NB; d++)
        pmax[d] <= '0;
    end else begin
      if (load)
        pool_rdy <= 1'b0;
      if (take) begin
        for (int d = 0; d < DEPTH_NB; d++)
          if (pcnt == 8'd0 || biased[d] > pmax[d])
            pmax[d] <= biased[d];
        if ({1'b0, pcnt} + 9'd1 >= {1'b0, eff}) begin
          pcnt     <= '0;
          pool_rdy <= 1'b1;
        end else begin
          pcnt <= pcnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dn_state   <= DN_EMPTY;
      result_bus <= '0;
    end else begin
      unique case (dn_state)
        DN_EMPTY: begin
          if (load) begin
            dn_state   <= DN_FULL;
            result_bus <= res_c;
          end
        end
        DN_FULL: begin
          if (result_rdy)
            dn_state <= DN_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layers.sv
// tb_conv_layers: directed vectors, expected results queued
// by the stimulus and popped by an output monitor.
module tb_conv_layers;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;
  logic        cfg_valid;
  logic [63:0] bias_bus;
  logic [63:0] kernel_bus;
  logic        kernel_rdy;
  logic [63:0] image_bus;
  logic        image_last;
  logic        image_val;
  logic        image_rdy;
  logic [15:0] result_bus;
  logic        result_val;
  logic        result_rdy;

  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];

  conv_layers dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_data   (cfg_data),
    .cfg_addr   (cfg_addr),
    .cfg_valid  (cfg_valid),
    .bias_bus   (bias_bus),
    .kernel_bus (kernel_bus),
    .kernel_rdy (kernel_rdy),
    .image_bus  (image_bus),
    .image_last (image_last),
    .image_val  (image_val),
    .image_rdy  (image_rdy),
    .result_bus (result_bus),
    .result_val (result_val),
    .result_rdy (result_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && result_val && result_rdy) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none",
                 result_bus);
      end else begin
        chk("result", {48'd0, result_bus}, {48'd0, q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] img(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic cfg_wr(input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = 5'd2;
    cfg_data  = d;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  task automatic beat(input logic [63:0] im, input logic last);
    int n = 0;
    while (!image_rdy && n < 200) begin
      tick(1);
      n++;
    end
    if (!image_rdy)
      chk("beat_rdy_timeout", 64'(image_rdy), 64'd1);
    image_val  = 1'b1;
    image_bus  = im;
    image_last = last;
    tick(1);
    image_val  = 1'b0;
    image_last = 1'b0;
  endtask

  task automatic latency(input string name);
    int n = 0;
    while (!result_val && n < 20) begin
      tick(1);
      n++;
    end
    chk(name, 64'(n), 64'd3);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      tick(1);
      n++;
    end
    tick(2);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stale;
    rst        = 1'b0;
    cfg_data   = '0;
    cfg_addr   = '0;
    cfg_valid  = 1'b0;
    bias_bus   = 64'h0000_0000_0018_0000;
    kernel_bus = {4{16'h1000}};
    image_bus  = '0;
    image_last = 1'b0;
    image_val  = 1'b1;
    result_rdy = 1'b1;
    tick(3);
    chk("rst_image_rdy", 64'(image_rdy), 64'd0);
    chk("rst_kernel_rdy", 64'(kernel_rdy), 64'd0);
    chk("rst_result_val", 64'(result_val), 64'd0);
    chk("rst_result_bus", 64'(result_bus), 64'd0);
    image_val = 1'b0;
    rst = 1'b1;
    tick(1);
    chk("rdy_after_rst", 64'(image_rdy), 64'd1);

    cfg_wr(32'h00_01_0C_1B);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    q.push_back(16'h0000);
    beat(img(16'hFB00, 16'hFA00, 16'hF900, 16'hF800), 1'b1);
    chk("rdy_low_after_last", 64'(image_rdy), 64'd0);
    latency("latency_relu");
    chk("rdy_back", 64'(image_rdy), 64'd1);
    drain();

    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    q.push_back(16'h1580);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b1);
    drain();

    beat(img(16'h3200, 16'h3200, 16'h3200, 16'h3080), 1'b1);
    q.push_back(16'h7FFF);
    q.push_back(16'h7F00);
    beat(img(16'h2000, 16'h2000, 16'h2000, 16'h1D80), 1'b1);
    drain();

    cfg_wr(32'h01_01_0C_1B);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    q.push_back(16'hF180);
    beat(img(16'hFB00, 16'hFA00, 16'hF900, 16'hF800), 1'b1);
    q.push_back(16'h8000);
    beat(img(16'hCE00, 16'hCE00, 16'hCE00, 16'hCC80), 1'b1);
    drain();

    cfg_wr(32'h00_02_0C_1B);
    beat(img(16'h0080, 16'h0080, 16'h0080, 16'h0000), 1'b1);
    tick(8);
    chk("pool_no_early", 64'(result_val), 64'd0);
    q.push_back(16'h0500);
    beat(img(16'h0100, 16'h0100, 16'h0100, 16'h0080), 1'b1);
    drain();
    beat(img(16'h0100, 16'h0100, 16'h0100, 16'h0080), 1'b1);
    q.push_back(16'h0500);
    beat(img(16'h0080, 16'h0080, 16'h0080, 16'h0000), 1'b1);
    drain();

    cfg_wr(32'h02_02_0C_1B);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    q.push_back(16'h1580);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b1);
    latency("latency_pool_bypass");
    drain();

    cfg_wr(32'h00_01_0C_1B);
    result_rdy = 1'b0;
    q.push_back(16'h1580);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b1);
    q.push_back(16'h0000);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    beat(img(16'hFB00, 16'hFA00, 16'hF900, 16'hF800), 1'b1);
    q.push_back(16'h1580);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b1);
    tick(12);
    chk("bp_rdy_low", 64'(image_rdy), 64'd0);
    chk("bp_val_held", 64'(result_val), 64'd1);
    chk("bp_bus_held", 64'(result_bus), 64'h1580);
    result_rdy = 1'b1;
    drain();

    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    rst = 1'b0;
    tick(2);
    chk("midrst_val", 64'(result_val), 64'd0);
    chk("midrst_rdy", 64'(image_rdy), 64'd0);
    rst = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      stale = stale | result_val;
    end
    chk("no_stale_val", 64'(stale), 64'd0);
    cfg_wr(32'h00_01_0C_1B);
    beat(img(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    q.push_back(16'h0000);
    beat(img(16'hFB00, 16'hFA00, 16'hF900, 16'hF800), 1'b1);
    latency("latency_after_rst");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
